sdr_wb_bist_master: RTL and testbench

Synthesizable Wishbone burst master that sits directly upstream of the SDRAM controller's Wishbone slave port. It executes queued write and read burst commands using an address-derived data pattern, so read-back checking is stateless. Read data is compared on-chip, and error and timeout status is reported. It replaces the behavioural traffic generator for FPGA bring-up and for self-test after sdr_init_done.

---
 rtl/sdr_bist_pkg.sv | 34 +++
 rtl/sdr_wb_bist_master_checker.sv | 94 +++++++++
 rtl/sdr_wb_bist_master.sv | 183 ++++++++++++++++++
 tb/tb_sdr_wb_bist_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_bist_pkg.sv
// -----------------------------------------------------------------------------
// sdr_bist_pkg
// Shared types and helpers for the SDRAM Wishbone BIST master.
//   bist_state_e  : sequencing FSM states
//   CTI_INCR/EOB  : Wishbone cycle-type identifiers used during a burst
//   bist_pattern  : address-derived test pattern ({addr,2'b00} ^ seed)
// -----------------------------------------------------------------------------
package sdr_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } bist_state_e;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    localparam int ERR_CNT_W = 16;

    // Functions in a package cannot be parameterised, so the pattern is
    // computed at a generous fixed width and callers truncate to DW.
    localparam int PAT_W = 128;

    // Byte address of the word, zero-extended, XOR the seed. Because the
    // expected value depends only on the address, read-back needs no storage.
    function automatic logic [PAT_W-1:0] bist_pattern(
        input logic [PAT_W-1:0] addr,
        input logic [PAT_W-1:0] seed
    );
        return (addr << 2) ^ seed;
    endfunction

endpackage

// File: rtl/sdr_wb_bist_master_checker.sv
// -----------------------------------------------------------------------------
// sdr_bist_checker
// Read-data checker and error bookkeeping for the BIST master.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   chk_i               : a read beat is being acknowledged this cycle
//   addr_i              : word address of that beat
//   rdata_i / exp_i     : received data / expected pattern
//   timeout_i           : the current burst is being aborted on timeout
//   err_clr_i           : clears all error state (wins over new events)
//   err_cnt_o           : mismatches plus timeouts, saturating
//   first_err_*_o       : sticky capture of the first mismatch
//   timeout_err_o       : sticky timeout flag
// -----------------------------------------------------------------------------
module sdr_bist_checker
    import sdr_bist_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 30
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 chk_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [DW-1:0]        rdata_i,
    input  logic [DW-1:0]        exp_i,
    input  logic                 timeout_i,
    input  logic                 err_clr_i,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic                 first_err_valid_o,
    output logic [AW-1:0]        first_err_addr_o,
    output logic [DW-1:0]        first_err_data_o,
    output logic                 timeout_err_o
);

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 fev_q, fev_d;
    logic [AW-1:0]        fea_q, fea_d;
    logic [DW-1:0]        fed_q, fed_d;
    logic                 to_q, to_d;
    logic                 mismatch;

    assign mismatch = chk_i && (rdata_i != exp_i);

    always_comb begin
        cnt_d = cnt_q;
        fev_d = fev_q;
        fea_d = fea_q;
        fed_d = fed_q;
        to_d  = to_q;
        if (err_clr_i) begin
            cnt_d = '0;
            fev_d = 1'b0;
            fea_d = '0;
            fed_d = '0;
            to_d  = 1'b0;
        end else begin
            // A mismatch and a timeout cannot coincide: timeout implies no ack.
            if ((mismatch || timeout_i) && (cnt_q != '1)) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
            if (mismatch && !fev_q) begin
                fev_d = 1'b1;
                fea_d = addr_i;
                fed_d = rdata_i;
            end
            if (timeout_i) begin
                to_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            fev_q <= 1'b0;
            fea_q <= '0;
            fed_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fev_q <= fev_d;
            fea_q <= fea_d;
            fed_q <= fed_d;
            to_q  <= to_d;
        end
    end

    assign err_cnt_o         = cnt_q;
    assign first_err_valid_o = fev_q;
    assign first_err_addr_o  = fea_q;
    assign first_err_data_o  = fed_q;
    assign timeout_err_o     = to_q;

endmodule

// File: rtl/sdr_wb_bist_master.sv
// -----------------------------------------------------------------------------
// sdr_wb_bist_master
// Wishbone burst master that writes and checks an address-derived pattern
// against the SDRAM controller's Wishbone slave port.
//   wb_clk_i, wb_rst_i      : clock, synchronous active-high reset
//   cmd_*                   : burst command (accepted in IDLE only)
//   cfg_seed                : pattern seed, sampled with the command
//   err_clr                 : clears error status
//   wb_*                    : Wishbone master interface (classic + CTI)
//   busy, done              : burst in flight / one-cycle completion pulse
//   err_cnt, first_err_*,
//   timeout_err             : error status from the checker
// -----------------------------------------------------------------------------
module sdr_wb_bist_master
    import sdr_bist_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 30,
    parameter int LW   = 8,
    parameter int TO_W = 10
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [LW-1:0]   cmd_len,
    input  logic [DW-1:0]   cfg_seed,
    input  logic            err_clr,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_addr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic [2:0]      wb_cti_o,
    input  logic            wb_ack_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_cnt,
    output logic            first_err_valid,
    output logic [AW-1:0]   first_err_addr,
    output logic [DW-1:0]   first_err_data,
    output logic            timeout_err
);

    // Value of the timeout counter during the last ack-less cycle allowed:
    // if no ack arrives now, the counter would reach all-ones -> abort.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    bist_state_e     state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [LW:0]     rem_q, rem_d;      // one extra bit so len 0 can hold 2^LW
    logic            we_q, we_d;
    logic [DW-1:0]   seed_q, seed_d;
    logic [TO_W-1:0] to_q, to_d;

    logic            in_burst;
    logic            last_beat;
    logic            timeout_hit;
    logic [DW-1:0]   pattern;

    assign in_burst    = (state_q == BURST);
    assign last_beat   = (rem_q == (LW+1)'(1));
    assign timeout_hit = in_burst && !wb_ack_i && (to_q == TO_LAST);
    assign pattern     = DW'(bist_pattern(PAT_W'(addr_q), PAT_W'(seed_q)));

    // NOTE: synchronous reset lives inside the clocked block; every register
    // here is a plain flop, so resetting all of them costs nothing.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            seed_q  <= '0;
            to_q    <= '0;
        end else begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            seed_q  <= seed_d;
            to_q    <= to_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a latch.
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = we_q;
        seed_d  = seed_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = BURST;
                    addr_d  = cmd_addr;
                    rem_d   = (cmd_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, cmd_len};
                    we_d    = cmd_write;
                    seed_d  = cfg_seed;
                    to_d    = '0;
                end
            end
            BURST: begin
                if (wb_ack_i) begin
                    to_d = '0;
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                        rem_d  = rem_q - (LW+1)'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded purely from registered state, so they are glitch-free
    // with respect to wb_ack_i and read back as zero outside a burst.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_stb_o  = 1'b0;
        wb_we_o   = 1'b0;
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_sel_o  = '0;
        wb_cti_o  = 3'b000;
        unique case (state_q)
            IDLE: cmd_ready = 1'b1;
            BURST: begin
                busy      = 1'b1;
                wb_cyc_o  = 1'b1;
                wb_stb_o  = 1'b1;
                wb_we_o   = we_q;
                wb_addr_o = addr_q;
                wb_dat_o  = pattern;
                wb_sel_o  = '1;
                wb_cti_o  = last_beat ? CTI_EOB : CTI_INCR;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    sdr_bist_checker #(
        .DW(DW),
        .AW(AW)
    ) u_checker (
        .clk_i             (wb_clk_i),
        .rst_i             (wb_rst_i),
        .chk_i             (in_burst && wb_ack_i && !we_q),
        .addr_i            (addr_q),
        .rdata_i           (wb_dat_i),
        .exp_i             (pattern),
        .timeout_i         (timeout_hit),
        .err_clr_i         (err_clr),
        .err_cnt_o         (err_cnt),
        .first_err_valid_o (first_err_valid),
        .first_err_addr_o  (first_err_addr),
        .first_err_data_o  (first_err_data),
        .timeout_err_o     (timeout_err)
    );

endmodule

// File: tb/tb_sdr_wb_bist_master.sv
// -----------------------------------------------------------------------------
// tb_sdr_wb_bist_master
// Self-checking bench: a Wishbone slave with a sparse memory, randomised wait
// states and data corruption, and a reference model of the error status.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdr_wb_bist_master;

    localparam int DW       = 32;
    localparam int AW       = 30;
    localparam int LW       = 8;
    localparam int TO_W     = 10;
    localparam int TO_LIMIT = (1 << TO_W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [LW-1:0]   cmd_len;
    logic [DW-1:0]   cfg_seed;
    logic            err_clr;
    logic            wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;
    logic            busy, done;
    logic [15:0]     err_cnt;
    logic            first_err_valid;
    logic [AW-1:0]   first_err_addr;
    logic [DW-1:0]   first_err_data;
    logic            timeout_err;

    always #5 clk = ~clk;

    sdr_wb_bist_master #(.DW(DW), .AW(AW), .LW(LW), .TO_W(TO_W)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cfg_seed        (cfg_seed),
        .err_clr         (err_clr),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_addr_o       (wb_addr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_cti_o        (wb_cti_o),
        .wb_ack_i        (wb_ack_i),
        .wb_dat_i        (wb_dat_i),
        .busy            (busy),
        .done            (done),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_data  (first_err_data),
        .timeout_err     (timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned   m_cnt;
    bit            m_fev;
    logic [AW-1:0] m_fea;
    logic [DW-1:0] m_fed;
    bit            m_to;
    logic [DW-1:0] mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] expect_pat(input logic [AW-1:0] a, input logic [DW-1:0] s);
        logic [63:0] wide;
        wide = 64'(a) * 64'd4;
        return DW'(wide) ^ s;
    endfunction

    function automatic void model_clear();
        m_cnt = 0; m_fev = 0; m_fea = '0; m_fed = '0; m_to = 0;
    endfunction

    function automatic void model_bump();
        if (m_cnt < 65535) m_cnt++;
    endfunction

    function automatic void model_mismatch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        model_bump();
        if (!m_fev) begin m_fev = 1; m_fea = a; m_fed = d; end
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_err_cnt"}, err_cnt, m_cnt);
        check({tag, "_fev"}, first_err_valid, m_fev);
        check({tag, "_fea"}, first_err_addr, m_fea);
        check({tag, "_fed"}, first_err_data, m_fed);
        check({tag, "_to_err"}, timeout_err, m_to);
    endtask

    // ---------------- slave behaviour controls ----------------
    int            max_wait    = 0;
    int            fixed_wait  = -1;
    int            stall_after = -1;
    int            clr_beat    = -1;
    bit            force_bad   = 0;
    bit            corrupt_map [256];
    logic [DW-1:0] corrupt_val = 32'hDEADBEEF;

    function automatic void reset_controls();
        max_wait = 0; fixed_wait = -1; stall_after = -1; clr_beat = -1; force_bad = 0;
        foreach (corrupt_map[i]) corrupt_map[i] = 0;
    endfunction

    function automatic int pick_wait();
        return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
    endfunction

    task automatic pulse_clr();
        err_clr = 1;
        @(posedge clk); @(negedge clk);
        err_clr = 0;
        model_clear();
        check_status("clr");
    endtask

    // Issue one command and act as the slave until the master leaves BURST.
    task automatic do_burst(input bit wr, input logic [AW-1:0] a0, input logic [LW-1:0] len,
                            input logic [DW-1:0] seed);
        int            beats, acks, idle, wait_left;
        bit            aborted, ack;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, rd;
        beats = (len == 0) ? (1 << LW) : int'(len);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a0; cmd_len = len; cfg_seed = seed;
        @(posedge clk); @(negedge clk);
        // Scramble command inputs: the master must have latched them.
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cfg_seed = $urandom;
        cmd_len = LW'($urandom);
        acks = 0; idle = 0; aborted = 0; wait_left = pick_wait();
        while (acks < beats && !aborted) begin
            ea = a0 + AW'(acks);
            ed = expect_pat(ea, seed);
            check("cyc", wb_cyc_o, 1);
            check("stb", wb_stb_o, 1);
            check("busy", busy, 1);
            ack = !(stall_after >= 0 && acks >= stall_after) && (wait_left == 0);
            if (ack) begin
                check("addr", wb_addr_o, ea);
                check("we", wb_we_o, wr);
                check("sel", wb_sel_o, 4'hF);
                check("cti", wb_cti_o, (acks == beats - 1) ? 3'b111 : 3'b010);
                if (wr) begin
                    check("wdat", wb_dat_o, ed);
                    mem[ea] = ed;
                end else begin
                    rd = mem.exists(ea) ? mem[ea] : ~ed;
                    if (force_bad) rd = ~ed;
                    if (corrupt_map[acks % 256]) rd = corrupt_val;
                    wb_dat_i = rd;
                    if (acks != clr_beat && rd !== ed) model_mismatch(ea, rd);
                end
                if (acks == clr_beat) begin
                    err_clr = 1;
                    model_clear();
                end
            end
            wb_ack_i = ack;
            @(posedge clk); @(negedge clk);
            wb_ack_i = 0; err_clr = 0; wb_dat_i = $urandom;
            if (ack) begin
                acks++; idle = 0; wait_left = pick_wait();
            end else begin
                idle++;
                if (wait_left > 0) wait_left--;
                if (idle == TO_LIMIT) begin
                    aborted = 1; model_bump(); m_to = 1;
                end
            end
        end
        check("done_pulse", done, 1);
        check("cyc_done", wb_cyc_o, 0);
        check("stb_done", wb_stb_o, 0);
        check("ready_done", cmd_ready, 0);
        check("busy_done", busy, 1);
        check_status("burst");
        @(negedge clk);
        check("done_low", done, 0);
        check("ready_back", cmd_ready, 1);
        check("busy_low", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, wb_cyc_o, 0);
        check({tag, "_stb"}, wb_stb_o, 0);
        check({tag, "_we"}, wb_we_o, 0);
        check({tag, "_addr"}, wb_addr_o, 0);
        check({tag, "_dat"}, wb_dat_o, 0);
        check({tag, "_sel"}, wb_sel_o, 0);
        check({tag, "_cti"}, wb_cti_o, 0);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check_status(tag);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] s0, s1;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cfg_seed = '0;
        err_clr = 0; wb_ack_i = 0; wb_dat_i = '0;
        model_clear();
        reset_controls();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        @(negedge clk);

        // 1: zero-wait write, pattern 0x40000.. with seed 0
        do_burst(1, 30'h1_0000, 8'd4, 32'h0);
        check("t1_pat", mem[30'h1_0003], 32'h0004_000C);
        // 2: read back clean
        do_burst(0, 30'h1_0000, 8'd4, 32'h0);
        check("t2_cnt", err_cnt, 0);
        // 3: corrupt beats 3 and 5 of a 5-beat read
        do_burst(1, 30'h1_0000, 8'd5, 32'h0);
        corrupt_map[2] = 1; corrupt_map[4] = 1;
        do_burst(0, 30'h1_0000, 8'd5, 32'h0);
        check("t3_cnt", err_cnt, 2);
        check("t3_fea", first_err_addr, 30'h1_0002);
        check("t3_fed", first_err_data, 32'hDEAD_BEEF);
        reset_controls();
        pulse_clr();

        // 4: slave acks beat 1 then stalls -> timeout abort
        stall_after = 1;
        do_burst(1, 30'h0000_0400, 8'd3, 32'h1234_5678);
        check("t4_to", timeout_err, 1);
        check("t4_cnt", err_cnt, 1);
        reset_controls();
        do_burst(1, 30'h0000_0500, 8'd2, 32'h0);
        pulse_clr();

        // ack in the last allowed cycle counts as an ack
        fixed_wait = TO_LIMIT - 1;
        do_burst(1, 30'h0000_0600, 8'd2, 32'hA5A5_0000);
        check("ack_at_limit_to", timeout_err, 0);
        reset_controls();

        // 5: len 0 wrapping burst
        do_burst(1, 30'h3FFF_FFFE, 8'd0, 32'h0F0F_F0F0);
        check("t5_wrap", mem.exists(30'h0000_00FD), 1);

        // err_clr coinciding with a mismatch: clear wins
        force_bad = 1; clr_beat = 2;
        do_burst(0, 30'h0200_0000, 8'd4, 32'h0);
        check("clr_win_cnt", err_cnt, 1);
        check("clr_win_fea", first_err_addr, 30'h0200_0003);
        reset_controls();
        pulse_clr();

        // randomised mix of writes and reads
        s0 = $urandom; s1 = $urandom;
        for (int i = 0; i < 40; i++) begin
            reset_controls();
            max_wait = int'($urandom_range(0, 3));
            a = AW'(32'h200 + $urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) corrupt_map[$urandom_range(0, 7)] = 1;
            corrupt_val = $urandom;
            do_burst(1'($urandom), a, LW'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0) ? s1 : s0);
        end
        reset_controls();

        // 6: reset asserted at beat 2 of a 6-beat write
        cmd_valid = 1; cmd_write = 1; cmd_addr = 30'h700; cmd_len = 8'd6; cfg_seed = 32'h55;
        @(posedge clk); @(negedge clk);
        cmd_valid = 0;
        check("t6_b1_addr", wb_addr_o, 30'h700);
        wb_ack_i = 1;
        @(posedge clk); @(negedge clk);
        wb_ack_i = 0;
        check("t6_b2_addr", wb_addr_o, 30'h701);
        rst = 1;
        @(posedge clk); @(negedge clk);
        model_clear();
        check_reset_outputs("t6_rst");
        rst = 0;
        @(negedge clk);
        check("t6_no_done", done, 0);
        check("t6_idle_cyc", wb_cyc_o, 0);

        // saturation: 256 fully mismatching 256-beat reads -> 65536 errors
        force_bad = 1;
        for (int i = 0; i < 256; i++) begin
            do_burst(0, AW'(32'h0300_0000 + i * 256), 8'd0, 32'h0);
        end
        check("sat_cnt", err_cnt, 16'hFFFF);
        reset_controls();
        pulse_clr();
        check("sat_clr", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
